// File: rtl/snow64_scalar_access_pipe_pkg.sv
// Shared types and decode helpers for the scalar extract/inject pipe.
// Element sizes are carried as log2(bytes) so that shifts replace multiplies.
package PkgSnow64ScalarAccess;

  typedef enum logic {
    OpExtract = 1'b0,
    OpInject  = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    DtUnsgnInt = 2'd0,
    DtSgnInt   = 2'd1,
    DtBFloat16 = 2'd2,
    DtReserved = 2'd3
  } data_type_e;

  typedef enum logic [1:0] {
    Its8  = 2'd0,
    Its16 = 2'd1,
    Its32 = 2'd2,
    Its64 = 2'd3
  } int_size_e;

  typedef struct packed {
    op_e        op;
    logic [1:0] esz_log2;
    logic       misaligned;
    logic       bad_type;
    logic       sign_en;
  } s1_ctrl_t;

  typedef struct packed {
    logic misaligned;
    logic bad_type;
  } out_flags_t;

  // BFloat16 is always two bytes; every other type takes its size from the int size field.
  function automatic logic [1:0] esz_log2(data_type_e dt, int_size_e its);
    logic [1:0] lg;
    case (dt)
      DtBFloat16: lg = 2'd1;
      default:    lg = its;
    endcase
    return lg;
  endfunction

endpackage

// File: rtl/snow64_scalar_access_pipe_slice.sv
// Combinational element extract (with optional sign extension) and inject on a line,
// addressed by an already-decoded element index and log2 element size.
module snow64_scalar_slice_unit
  import PkgSnow64ScalarAccess::*;
#(
  parameter int LINE_WIDTH   = 256,
  parameter int SCALAR_WIDTH = 64,
  parameter int OFFSET_WIDTH = $clog2(LINE_WIDTH / 8)
) (
  input  op_e                     op_i,
  input  logic [1:0]              esz_log2_i,
  input  logic [OFFSET_WIDTH-1:0] idx_i,
  input  logic                    sign_en_i,
  input  logic [LINE_WIDTH-1:0]   line_i,
  input  logic [SCALAR_WIDTH-1:0] scalar_i,
  output logic [SCALAR_WIDTH-1:0] scalar_o,
  output logic [LINE_WIDTH-1:0]   line_o
);

  localparam int BitW = $clog2(LINE_WIDTH);

  logic [BitW-1:0]         base_s;
  logic [SCALAR_WIDTH-1:0] mask_s;
  logic [SCALAR_WIDTH-1:0] raw_s;
  logic                    sign_bit_s;
  logic [SCALAR_WIDTH-1:0] ext_s;
  logic [LINE_WIDTH-1:0]   line_mask_s;
  logic [LINE_WIDTH-1:0]   ins_s;

  // Bit base of the element, element mask, extension and line merge.
  always_comb begin
    base_s = (BitW'(idx_i) << esz_log2_i) << 3'd3;
    case (esz_log2_i)
      2'd0:    mask_s = SCALAR_WIDTH'(8'hFF);
      2'd1:    mask_s = SCALAR_WIDTH'(16'hFFFF);
      2'd2:    mask_s = SCALAR_WIDTH'(32'hFFFF_FFFF);
      default: mask_s = '1;
    endcase
    raw_s = SCALAR_WIDTH'(line_i >> base_s) & mask_s;
    case (esz_log2_i)
      2'd0:    sign_bit_s = raw_s[7];
      2'd1:    sign_bit_s = raw_s[15];
      2'd2:    sign_bit_s = raw_s[31];
      default: sign_bit_s = raw_s[SCALAR_WIDTH-1];
    endcase
    if (sign_en_i && sign_bit_s) begin
      ext_s = raw_s | ~mask_s;
    end else begin
      ext_s = raw_s;
    end
    line_mask_s = LINE_WIDTH'(mask_s) << base_s;
    ins_s       = LINE_WIDTH'(scalar_i & mask_s) << base_s;
    if (op_i == OpInject) begin
      scalar_o = '0;
      line_o   = (line_i & ~line_mask_s) | ins_s;
    end else begin
      scalar_o = ext_s;
      line_o   = line_i;
    end
  end

endmodule

// File: rtl/snow64_scalar_access_pipe.sv
// Two-stage scalar extract/inject pipe over one LAR line: S1 decodes the request,
// S2 (the output register) holds the sliced result. Valid/ready on both sides.
module snow64_scalar_access_pipe
  import PkgSnow64ScalarAccess::*;
#(
  parameter int LINE_WIDTH   = 256,
  parameter int SCALAR_WIDTH = 64,
  parameter int OFFSET_WIDTH = $clog2(LINE_WIDTH / 8),
  parameter int TAG_WIDTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_op,
  input  logic [1:0]              in_data_type,
  input  logic [1:0]              in_int_type_size,
  input  logic [OFFSET_WIDTH-1:0] in_byte_offset,
  input  logic [LINE_WIDTH-1:0]   in_line,
  input  logic [SCALAR_WIDTH-1:0] in_scalar,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SCALAR_WIDTH-1:0] out_scalar,
  output logic [LINE_WIDTH-1:0]   out_line,
  output logic [TAG_WIDTH-1:0]    out_tag,
  output logic                    out_misaligned,
  output logic                    out_bad_type
);

  logic                    advance_s;
  logic                    accept_s;
  logic [1:0]              esz_lg_s;
  logic [OFFSET_WIDTH-1:0] esz_mask_s;

  logic                    s1_valid_q, s1_valid_d;
  s1_ctrl_t                s1_ctrl_q, s1_ctrl_d;
  logic [OFFSET_WIDTH-1:0] s1_idx_q, s1_idx_d;
  logic [LINE_WIDTH-1:0]   s1_line_q, s1_line_d;
  logic [SCALAR_WIDTH-1:0] s1_scalar_q, s1_scalar_d;
  logic [TAG_WIDTH-1:0]    s1_tag_q, s1_tag_d;

  logic                    out_valid_q, out_valid_d;
  logic [SCALAR_WIDTH-1:0] out_scalar_q, out_scalar_d;
  logic [LINE_WIDTH-1:0]   out_line_q, out_line_d;
  logic [TAG_WIDTH-1:0]    out_tag_q, out_tag_d;
  out_flags_t              out_flags_q, out_flags_d;

  logic [SCALAR_WIDTH-1:0] slice_scalar_s;
  logic [LINE_WIDTH-1:0]   slice_line_s;

  // S1 and S2 move together, so S1 may accept whenever it is empty or S2 is about to drain.
  assign advance_s = !out_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || advance_s;
  assign accept_s  = in_valid && in_ready;

  assign esz_lg_s   = esz_log2(data_type_e'(in_data_type), int_size_e'(in_int_type_size));
  assign esz_mask_s = (OFFSET_WIDTH'(1) << esz_lg_s) - OFFSET_WIDTH'(1);

  // Stage 1 next state: decode on accept, drop valid when handed to S2 without refill.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_ctrl_d   = s1_ctrl_q;
    s1_idx_d    = s1_idx_q;
    s1_line_d   = s1_line_q;
    s1_scalar_d = s1_scalar_q;
    s1_tag_d    = s1_tag_q;
    if (accept_s) begin
      s1_valid_d           = 1'b1;
      s1_ctrl_d.op         = op_e'(in_op);
      s1_ctrl_d.esz_log2   = esz_lg_s;
      s1_ctrl_d.misaligned = |(in_byte_offset & esz_mask_s);
      s1_ctrl_d.bad_type   = (in_data_type == DtReserved);
      s1_ctrl_d.sign_en    = (in_data_type == DtSgnInt);
      s1_idx_d             = in_byte_offset >> esz_lg_s;
      s1_line_d            = in_line;
      s1_scalar_d          = in_scalar;
      s1_tag_d             = in_tag;
    end else if (advance_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  snow64_scalar_slice_unit #(
    .LINE_WIDTH   (LINE_WIDTH),
    .SCALAR_WIDTH (SCALAR_WIDTH),
    .OFFSET_WIDTH (OFFSET_WIDTH)
  ) u_slice (
    .op_i       (s1_ctrl_q.op),
    .esz_log2_i (s1_ctrl_q.esz_log2),
    .idx_i      (s1_idx_q),
    .sign_en_i  (s1_ctrl_q.sign_en),
    .line_i     (s1_line_q),
    .scalar_i   (s1_scalar_q),
    .scalar_o   (slice_scalar_s),
    .line_o     (slice_line_s)
  );

  // Output register next state; contents hold while stalled.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_scalar_d = out_scalar_q;
    out_line_d   = out_line_q;
    out_tag_d    = out_tag_q;
    out_flags_d  = out_flags_q;
    if (advance_s) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_tag_d              = s1_tag_q;
        out_flags_d.misaligned = s1_ctrl_q.misaligned;
        out_flags_d.bad_type   = s1_ctrl_q.bad_type;
        if (s1_ctrl_q.bad_type) begin
          out_scalar_d = '0;
          out_line_d   = '0;
        end else begin
          out_scalar_d = slice_scalar_s;
          out_line_d   = slice_line_s;
        end
      end else begin
        out_tag_d = out_tag_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_ctrl_q    <= '0;
      s1_idx_q     <= '0;
      s1_line_q    <= '0;
      s1_scalar_q  <= '0;
      s1_tag_q     <= '0;
      out_valid_q  <= 1'b0;
      out_scalar_q <= '0;
      out_line_q   <= '0;
      out_tag_q    <= '0;
      out_flags_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_ctrl_q    <= s1_ctrl_d;
      s1_idx_q     <= s1_idx_d;
      s1_line_q    <= s1_line_d;
      s1_scalar_q  <= s1_scalar_d;
      s1_tag_q     <= s1_tag_d;
      out_valid_q  <= out_valid_d;
      out_scalar_q <= out_scalar_d;
      out_line_q   <= out_line_d;
      out_tag_q    <= out_tag_d;
      out_flags_q  <= out_flags_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_scalar     = out_scalar_q;
  assign out_line       = out_line_q;
  assign out_tag        = out_tag_q;
  assign out_misaligned = out_flags_q.misaligned;
  assign out_bad_type   = out_flags_q.bad_type;

endmodule

// File: doc/snow64_scalar_access_pipe.md
Name: snow64_scalar_access_pipe

Overview:
- Pipelined, parametrised scalar extract/inject unit over one LAR data line.
- Handles two operation types:
  - extract: selects one element from the line and sign- or zero-extends it to SCALAR_WIDTH.
  - inject: writes one scalar element into a copy of the line.
- Uses valid/ready handshakes on input and output, with a tag carried through so the LAR/ALU side can match responses to requests.
- Adds error flags for misaligned offsets and reserved data types.

Parameters:
- LINE_WIDTH, 256: line width in bits; must be a power of 2 and at least SCALAR_WIDTH.
- SCALAR_WIDTH, 64: scalar width in bits; fixed maximum element size.
- OFFSET_WIDTH, $clog2(LINE_WIDTH/8): width of the byte offset within the line.
- TAG_WIDTH, 4: width of the opaque request tag.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_op  in  1  0 = extract, 1 = inject
- in_data_type  in  2  0 UnsgnInt, 1 SgnInt, 2 BFloat16, 3 Reserved
- in_int_type_size  in  2  0 = 8, 1 = 16, 2 = 32, 3 = 64 bits; ignored for BFloat16, which is 16 bits
- in_byte_offset  in  OFFSET_WIDTH  byte offset of the element
- in_line  in  LINE_WIDTH  line to read from or modify
- in_scalar  in  SCALAR_WIDTH  inject value; only the low element-width bits are used
- in_tag  in  TAG_WIDTH  passthrough tag
- out_valid  out  1  response valid
- out_ready  in  1  response consumed when out_valid && out_ready
- out_scalar  out  SCALAR_WIDTH  extracted value after extension; 0 for inject
- out_line  out  LINE_WIDTH  modified line for inject; in_line unchanged for extract
- out_tag  out  TAG_WIDTH  tag of the request
- out_misaligned  out  1  byte offset was not a multiple of the element size
- out_bad_type  out  1  data type was Reserved

Behaviour:
- Reset (asynchronous on rst_n low): both stage valids = 0, out_valid = 0, and all output data, tag and flags = 0. in_ready = 1 once reset is released.
- Stage 1 (S1), on accept, registers:
  - op, tag, line and scalar;
  - element size in bytes (esz);
  - element index = in_byte_offset >> log2(esz), with the low bits dropped;
  - misaligned = |(in_byte_offset & (esz-1));
  - bad_type = (data_type == 3);
  - sign-extend enable = (data_type == 1).
- Stage 2 (S2, the output register) computes from the S1 contents:
  - extract: elem = line[idx*esz*8 +: esz*8], then sign- or zero-extended to SCALAR_WIDTH. BFloat16 is always zero-extended (raw bits).
  - inject: line with the same slice replaced by scalar[esz*8-1:0]; all other bits unchanged.
  - bad_type: out_scalar = 0 and out_line = 0, regardless of op.
- Misaligned requests still complete using the truncated index. The flag is informational only.
- Latency: response appears 2 cycles after accept when out_ready is held high. Throughput is one request per cycle.
- Advance rules:
  - S2 loads when !out_valid || out_ready.
  - S1 advances to S2 under the same condition.
  - in_ready = !s1_valid || (!out_valid || out_ready). This is combinational from out_ready, with no loop back to in_valid.
- A simultaneous pop of S2, move of S1 to S2 and accept into S1 in one cycle is legal. No bubble is inserted.
- Backpressure: at most 2 requests are in flight. Order is strictly preserved and no request is dropped or duplicated.
- Output stability: out_* hold stable while out_valid && !out_ready.
- Reset mid-operation discards all in-flight requests and produces no response for them.

Decomposition:
- Shared package PkgSnow64ScalarAccess holds:
  - enums for op, data type and int type size;
  - struct types for the stage-1 and output payloads;
  - a function that maps int type size to esz.
- One natural sub-module, snow64_scalar_slice_unit: combinational extract-with-extension and inject on a decoded (index, esz, sign) triple. It is instantiated once, in S2.

Test Plan:
- Extract, SgnInt, 8-bit, offset 5, with line byte 5 = 0x80 and all other bytes 0 → out_scalar = 0xFFFF_FFFF_FFFF_FF80, out_valid 2 cycles after accept, misaligned = 0. The same request as UnsgnInt → 0x0000_0000_0000_0080.
- Inject, UnsgnInt, 16-bit, 0xBEEF at offset 6 into an all-zero line → out_line[63:48] = 0xBEEF and all other bits 0; out_scalar = 0.
- Extract, SgnInt, 32-bit, offset 6, with line bytes 4..7 = 0x01,0x02,0x03,0x84 → out_scalar = 0xFFFF_FFFF_8403_0201 (bytes 4..7, little-endian), misaligned = 1.
- Reserved type with inject and tag 0xA → out_bad_type = 1, out_line = 0, out_tag = 0xA.
- Backpressure: out_ready low while 3 requests with tags 1, 2, 3 are offered → in_ready drops after 2 accepts. With out_ready high, responses emerge as tags 1, 2, 3 on consecutive cycles, and outputs are stable while stalled.
- rst_n pulsed low with 2 requests in flight → out_valid = 0 immediately, and the next request completes normally with 2-cycle latency.
